bram_dp_arbiter: RTL and testbench

- Shares one simple dual-port block RAM among several clients.
  - Write port A: 1024x16, single clock.
  - Read port B: one-cycle registered read.
- NUM_WR write clients arbitrate for port A; NUM_RD read clients arbitrate for port B. Each port has its own independent round-robin arbiter.
- Drives the RAM enables, write enable, addresses and write data.
- Returns read data to the winning reader with a one-hot valid, one cycle after grant.
- Sits between client logic and the dual-port RAM instance.

---
 rtl/bram_arb_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/bram_dp_arbiter.sv | 99 +++++++++
 tb/tb_bram_dp_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared constants and helpers for the dual-port BRAM arbiter.
// Default RAM geometry and the arbiter pointer-width helper.
package bram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 16;

    // Pointer width for an N-way arbiter; never narrower than one bit.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, search starts at ptr.
// ptr moves to one past the winner on every grant and holds otherwise.
module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int unsigned PW = ptr_w(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt_idx;
    logic          found;

    // First pass covers indices at or above ptr, second pass wraps to the low ones.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (!found && req[i] && (PW'(i) >= ptr)) begin
                gnt[i]  = 1'b1;
                gnt_idx = PW'(i);
                found   = 1'b1;
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            if (!found && req[i]) begin
                gnt[i]  = 1'b1;
                gnt_idx = PW'(i);
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

endmodule

// File: rtl/bram_dp_arbiter.sv
// Arbitrates NUM_WR writers onto RAM port A and NUM_RD readers onto port B.
// Define BRAM_DP_ARBITER_FWD_EN for write-first behaviour on same-address collisions.
module bram_dp_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned NUM_WR = 2,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_WR-1:0]        wr_req,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic [NUM_WR-1:0]        wr_gnt,
    input  logic [NUM_RD-1:0]        rd_req,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_gnt,
    output logic [NUM_RD-1:0]        rd_rvalid,
    output logic [DATA_W-1:0]        rd_rdata,
    output logic                     ram_ena,
    output logic                     ram_wea,
    output logic [ADDR_W-1:0]        ram_addra,
    output logic [DATA_W-1:0]        ram_dia,
    output logic                     ram_enb,
    output logic [ADDR_W-1:0]        ram_addrb,
    input  logic [DATA_W-1:0]        ram_dob
);

    rr_arbiter #(.N(NUM_WR)) u_wr_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (wr_req),
        .gnt   (wr_gnt)
    );

    rr_arbiter #(.N(NUM_RD)) u_rd_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (rd_req),
        .gnt   (rd_gnt)
    );

    // Port A mux; grant is one-hot so an OR of gated slices is exact.
    always_comb begin
        ram_addra = '0;
        ram_dia   = '0;
        for (int i = 0; i < int'(NUM_WR); i++) begin
            if (wr_gnt[i]) begin
                ram_addra = ram_addra | wr_addr[i*ADDR_W +: ADDR_W];
                ram_dia   = ram_dia   | wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        ram_addrb = '0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            if (rd_gnt[i]) begin
                ram_addrb = ram_addrb | rd_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign ram_ena = |wr_gnt;
    assign ram_wea = |wr_gnt;
    assign ram_enb = |rd_gnt;

    // Read data returns one cycle after grant, matching the RAM's registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_rvalid <= '0;
        end else begin
            rd_rvalid <= rd_gnt;
        end
    end

`ifdef BRAM_DP_ARBITER_FWD_EN
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    // Capture the new write data when it collides with the read being issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
        end else begin
            fwd_hit  <= ram_ena && ram_enb && (ram_addra == ram_addrb);
            fwd_data <= ram_dia;
        end
    end

    assign rd_rdata = fwd_hit ? fwd_data : ram_dob;
`else
    assign rd_rdata = ram_dob;
`endif

endmodule

// File: tb/tb_bram_dp_arbiter.sv
// Self-checking bench for bram_dp_arbiter with an external RAM model and a
// transaction-level reference (round-robin pick + memory array + one-cycle read queue).
module tb_bram_dp_arbiter;

    localparam int NW = 2;
    localparam int NR = 2;
    localparam int AW = 10;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NW-1:0]     wr_req;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*DW-1:0]  wr_data;
    logic [NW-1:0]     wr_gnt;
    logic [NR-1:0]     rd_req;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR-1:0]     rd_gnt;
    logic [NR-1:0]     rd_rvalid;
    logic [DW-1:0]     rd_rdata;
    logic              ram_ena;
    logic              ram_wea;
    logic [AW-1:0]     ram_addra;
    logic [DW-1:0]     ram_dia;
    logic              ram_enb;
    logic [AW-1:0]     ram_addrb;
    logic [DW-1:0]     ram_dob = '0;

    bram_dp_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_WR(NW), .NUM_RD(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_gnt    (wr_gnt),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_rvalid (rd_rvalid),
        .rd_rdata  (rd_rdata),
        .ram_ena   (ram_ena),
        .ram_wea   (ram_wea),
        .ram_addra (ram_addra),
        .ram_dia   (ram_dia),
        .ram_enb   (ram_enb),
        .ram_addrb (ram_addrb),
        .ram_dob   (ram_dob)
    );

    always #5 clk = ~clk;

    // Physical RAM: read-first simple dual port with registered read.
    logic [DW-1:0] mem [1024] = '{default: '0};
    always @(posedge clk) begin
        if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
        if (ram_enb) ram_dob <= mem[ram_addrb];
    end

    // Reference state
    logic [DW-1:0] ref_mem [1024] = '{default: '0};
    int            wp, rp, wg_last, rg_last;
    logic [NR-1:0] exp_rv;
    logic [DW-1:0] exp_rd;
    int            wwait [NW];
    int            rwait [NR];
    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] coll_exp;

    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [1:0] req, input int ptr, input int n);
        for (int k = 0; k < n; k++) begin
            if (req[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    function automatic logic [31:0] onehot(input int g);
        return (g >= 0) ? (32'd1 << g) : 32'd0;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(1016, 1023));
        return AW'($urandom_range(0, 7));
    endfunction

    task automatic clear_inputs();
        wr_req = '0; wr_addr = '0; wr_data = '0;
        rd_req = '0; rd_addr = '0;
    endtask

    task automatic model_reset();
        wp = 0; rp = 0; exp_rv = '0; exp_rd = '0;
        wg_last = -1; rg_last = -1;
        for (int i = 0; i < NW; i++) wwait[i] = 0;
        for (int i = 0; i < NR; i++) rwait[i] = 0;
    endtask

    // Compare every DUT output with the reference, then advance the reference by one edge.
    task automatic tick_check();
        int wg, rg;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd;
        wa = '0; ra = '0; wd = '0;
        @(negedge clk);
        wg = pick(wr_req, wp, NW);
        rg = pick(rd_req, rp, NR);
        chk("wr_gnt", 32'(wr_gnt), onehot(wg));
        chk("ram_ena", 32'(ram_ena), 32'(wg >= 0));
        chk("ram_wea", 32'(ram_wea), 32'(wg >= 0));
        if (wg >= 0) begin
            wa = wr_addr[wg*AW +: AW];
            wd = wr_data[wg*DW +: DW];
            chk("ram_addra", 32'(ram_addra), 32'(wa));
            chk("ram_dia", 32'(ram_dia), 32'(wd));
        end
        chk("rd_gnt", 32'(rd_gnt), onehot(rg));
        chk("ram_enb", 32'(ram_enb), 32'(rg >= 0));
        if (rg >= 0) begin
            ra = rd_addr[rg*AW +: AW];
            chk("ram_addrb", 32'(ram_addrb), 32'(ra));
        end
        chk("rd_rvalid", 32'(rd_rvalid), 32'(exp_rv));
        if (exp_rv != '0) chk("rd_rdata", 32'(rd_rdata), 32'(exp_rd));
        for (int i = 0; i < NW; i++) begin
            if (wr_req[i] && wg != i) begin
                wwait[i]++;
                chk("wr_wait_bound", 32'(wwait[i] < NW), 32'd1);
            end else wwait[i] = 0;
        end
        for (int i = 0; i < NR; i++) begin
            if (rd_req[i] && rg != i) begin
                rwait[i]++;
                chk("rd_wait_bound", 32'(rwait[i] < NR), 32'd1);
            end else rwait[i] = 0;
        end
        if (rg >= 0) begin
            exp_rv = NR'(onehot(rg));
            exp_rd = ref_mem[ra];
`ifdef BRAM_DP_ARBITER_FWD_EN
            if (wg >= 0 && wa == ra) exp_rd = wd;
`endif
            rp = (rg + 1) % NR;
        end else begin
            exp_rv = '0;
        end
        if (wg >= 0) begin
            ref_mem[wa] = wd;
            wp = (wg + 1) % NW;
        end
        wg_last = wg;
        rg_last = rg;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        tick_check();
        chk("reset_rvalid", 32'(rd_rvalid), 32'd0);
        adv();
        rst_n = 1'b1;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        do_reset();

        // Single write then read-back at 0x005.
        wr_req = 2'b01; wr_addr[9:0] = 10'h005; wr_data[15:0] = 16'hBEEF;
        tick_check();
        chk("t1_wr_gnt", 32'(wr_gnt), 32'h1);
        chk("t1_ena_wea", 32'({ram_ena, ram_wea}), 32'h3);
        chk("t1_addra", 32'(ram_addra), 32'h005);
        chk("t1_dia", 32'(ram_dia), 32'hBEEF);
        adv();
        clear_inputs();
        rd_req = 2'b01; rd_addr[9:0] = 10'h005;
        tick_check();
        chk("t1_rd_gnt", 32'(rd_gnt), 32'h1);
        adv();
        clear_inputs();
        tick_check();
        chk("t1_rvalid", 32'(rd_rvalid), 32'h1);
        chk("t1_rdata", 32'(rd_rdata), 32'hBEEF);
        adv();

        // Two writers holding req alternate strictly.
        do_reset();
        wr_req = 2'b11; wr_addr = {10'h020, 10'h010}; wr_data = {16'h0202, 16'h0101};
        for (int c = 0; c < 6; c++) begin
            tick_check();
            chk("t2_wr_seq", 32'(wr_gnt), (c % 2 == 0) ? 32'h1 : 32'h2);
            adv();
        end
        clear_inputs();

        // Fill 0x000/0x3FF then two readers alternate.
        wr_req = 2'b11; wr_addr = {10'h3FF, 10'h000}; wr_data = {16'h2222, 16'h1111};
        tick_check(); adv();
        tick_check(); adv();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            rd_req = (c < 4) ? 2'b11 : 2'b00;
            rd_addr = {10'h3FF, 10'h000};
            tick_check();
            if (c < 4) chk("t3_rd_gnt", 32'(rd_gnt), (c % 2 == 1) ? 32'h2 : 32'h1);
            if (c > 0) begin
                chk("t3_rvalid", 32'(rd_rvalid), ((c - 1) % 2 == 1) ? 32'h2 : 32'h1);
                chk("t3_rdata", 32'(rd_rdata), ((c - 1) % 2 == 1) ? 32'h2222 : 32'h1111);
            end
            adv();
        end
        clear_inputs();

        // Same-cycle collision at 0x00A.
        wr_req = 2'b01; wr_addr[9:0] = 10'h00A; wr_data[15:0] = 16'h0001;
        tick_check(); adv();
        wr_data[15:0] = 16'hCAFE;
        rd_req = 2'b01; rd_addr[9:0] = 10'h00A;
        tick_check(); adv();
        clear_inputs();
`ifdef BRAM_DP_ARBITER_FWD_EN
        coll_exp = 16'hCAFE;
`else
        coll_exp = 16'h0001;
`endif
        tick_check();
        chk("t4_rvalid", 32'(rd_rvalid), 32'h1);
        chk("t4_rdata", 32'(rd_rdata), 32'(coll_exp));
        adv();

        // Reset between a read grant and its data cycle suppresses rd_rvalid.
        rd_req = 2'b10; rd_addr = {10'h005, 10'h000};
        tick_check();
        chk("t5_rd_gnt", 32'(rd_gnt), 32'h2);
        #1;
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        adv();
        rst_n = 1'b1;
        tick_check();
        chk("t5_rvalid_killed", 32'(rd_rvalid), 32'h0);
        adv();
        rd_req = 2'b11; rd_addr = {10'h3FF, 10'h000};
        tick_check();
        chk("t5_first_gnt", 32'(rd_gnt), 32'h1);
        adv();
        clear_inputs();
        tick_check();
        chk("t5_rdata", 32'(rd_rdata), 32'h1111);
        adv();

        // Extreme addresses must not alias.
        wr_req = 2'b01; wr_addr[9:0] = 10'h3FF; wr_data[15:0] = 16'hA5A5;
        tick_check(); adv();
        wr_addr[9:0] = 10'h000; wr_data[15:0] = 16'h5A5A;
        tick_check(); adv();
        clear_inputs();
        rd_req = 2'b01; rd_addr[9:0] = 10'h3FF;
        tick_check(); adv();
        rd_addr[9:0] = 10'h000;
        tick_check();
        chk("t6_rdata_3ff", 32'(rd_rdata), 32'hA5A5);
        adv();
        clear_inputs();
        tick_check();
        chk("t6_rdata_000", 32'(rd_rdata), 32'h5A5A);
        adv();

        // Random traffic obeying the hold-until-granted handshake.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NW; i++) begin
                if (!wr_req[i] || wg_last == i) begin
                    wr_req[i] = ($urandom_range(0, 99) < 60);
                    wr_addr[i*AW +: AW] = rand_addr();
                    wr_data[i*DW +: DW] = DW'($urandom);
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (!rd_req[i] || rg_last == i) begin
                    rd_req[i] = ($urandom_range(0, 99) < 60);
                    rd_addr[i*AW +: AW] = rand_addr();
                end
            end
            tick_check();
            adv();
        end
        clear_inputs();
        tick_check();
        adv();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
